fir_decimate: RTL
=================

Name: fir_decimate

Overview:
- Sits directly downstream of the FIR low-pass filter in the FMCW receive chain.
- Consumes one filtered sample per `ce` strobe and keeps every DEC-th sample, aligned to chirp start.
- Groups kept samples into frames of FRAME_LEN and buffers them in a small FIFO.
- Presents them on a valid/ready stream to the FFT/readout stage, with a last-sample marker per frame.

Parameters:
- IW, 14, input sample width (signed two's complement), equal to FIR output width.
- OW, 14, output sample width; OW <= IW.
- DEC, 20, decimation factor; DEC >= 1.
- FRAME_LEN, 1024, decimated samples per chirp frame; >= 2.
- FIFO_DEPTH, 16, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  input sample strobe; data_i valid when high.
- data_i  input  IW  filtered sample from FIR stage.
- frame_start  input  1  single-cycle pulse at chirp start.
- data_o  output  OW  head-of-FIFO sample.
- valid_o  output  1  data_o/last_o valid.
- ready_i  input  1  downstream accepts when high.
- last_o  output  1  head sample is final sample of its frame.
- busy_o  output  1  high while in ACTIVE.
- overflow_o  output  1  sticky: a kept sample was dropped.

Behaviour:
- Reset (rst high, asynchronous) clears all state:
  - state IDLE; phase counter 0; sample counter 0; FIFO empty.
  - valid_o=0, last_o=0, busy_o=0, overflow_o=0, data_o=0.
- Counters:
  - phase counter ($clog2(DEC) bits) counts 0..DEC-1 and wraps.
  - sample counter ($clog2(FRAME_LEN) bits) counts 0..FRAME_LEN-1.
- State IDLE:
  - ce ignored.
  - frame_start -> ACTIVE; phase and sample counters set to 0 the same cycle.
- frame_start and ce in the same cycle:
  - The current data_i is treated as phase 0 and kept as frame sample 0.
  - Applies both from IDLE and as a restart from ACTIVE.
- State ACTIVE, on each ce:
  - If phase==0, the sample is kept and pushed with last flag = (sample counter == FRAME_LEN-1).
  - phase increments, wrapping DEC-1 -> 0.
  - Each kept sample increments the sample counter.
  - The push of sample FRAME_LEN-1 returns the FSM to IDLE on the next edge.
- DEC=1: every ce sample is kept.
- frame_start during ACTIVE (without completing): restart.
  - Counters set to 0; stay ACTIVE.
  - Entries already in the FIFO are untouched; the aborted frame never gets a last flag.
- Width rule: kept value = data_i[IW-1 -: OW], i.e. arithmetic truncation of IW-OW LSBs, no rounding.
- FIFO push when full:
  - Sample is dropped; overflow_o set to 1, sticky until rst.
  - Counters still advance, so frame alignment is preserved.
  - If the dropped sample was the last one, the FSM still returns to IDLE.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- FIFO read side:
  - valid_o = not empty; data_o/last_o show the head entry.
  - Pop on valid_o & ready_i.
  - Push and pop in the same cycle while empty is not possible (push latency 1).
- Latency: sample kept on edge N appears on data_o with valid_o=1 after edge N when the FIFO was empty (one clock).
- Output stability: data_o/last_o/valid_o hold stable while valid_o=1 and ready_i=0.
- busy_o = (state == ACTIVE).

Test Plan (DEC=4, FRAME_LEN=8, FIFO_DEPTH=4, IW=OW=14 unless stated):
- Reset then ce every cycle with data_i = 0,1,2,… and no frame_start, ready_i=1 -> valid_o never asserts; busy_o=0.
- frame_start coincident with ce on data 100, ce continuous, data incrementing, ready_i=1 -> outputs 100,104,…,128 in that order; last_o=1 only on 128; busy_o drops after 128; further ce produce nothing.
- Same as previous scenario but ready_i=0 throughout -> 4 entries (100..112) held; 116..128 dropped; overflow_o=1; busy_o falls after the 8th kept sample. Raising ready_i then yields exactly 100,104,108,112 with last_o=0.
- frame_start at data 0, then a second frame_start after 3 kept samples at data 50 -> outputs 0,4,8 then 50,54,…,78 with last_o only on 78.
- IW=16, OW=12, DEC=1, input 0x8FFF -> data_o = 0x8FF. Assert rst mid-frame with 2 entries queued -> valid_o=0, busy_o=0, overflow_o=0 immediately (asynchronous).

Source files
------------

// File: rtl/fir_decimate.sv
// rtl/fir_decimate.sv - decimator and frame packer between the FIR low-pass and the FFT readout
//
// Keeps every DEC-th filtered sample, phase-aligned to frame_start, groups
// the kept samples into frames of FRAME_LEN and queues them in a small FIFO
// that drains over a valid/ready stream.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   ce          input sample strobe, data_i valid when high
//   data_i      filtered sample (IW bits, signed)
//   frame_start single-cycle pulse at chirp start
//   data_o      head-of-FIFO sample (OW bits, truncated from data_i)
//   valid_o     data_o/last_o valid
//   ready_i     downstream accepts when high
//   last_o      head sample is the final sample of its frame
//   busy_o      high while a frame is being collected
//   overflow_o  sticky: a kept sample was dropped because the FIFO was full

module fir_decimate #(
    parameter int IW         = 14,
    parameter int OW         = 14,
    parameter int DEC        = 20,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [IW-1:0] data_i,
    input  logic          frame_start,
    output logic [OW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          busy_o,
    output logic          overflow_o
);

    // DEC=1 would give a zero-width phase counter; keep one bit that stays 0.
    localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int SW = $clog2(FRAME_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0]   PHASE_MAX  = PW'(DEC - 1);
    // Phase following a kept frame_start sample.
    localparam logic [PW-1:0]   PHASE_NEXT = (DEC > 1) ? PW'(1) : '0;
    localparam logic [SW-1:0]   SAMPLE_MAX = SW'(FRAME_LEN - 1);
    localparam logic [AW:0]     FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t         state;
    logic [PW-1:0]  phase;
    logic [SW-1:0]  sample_cnt;

    logic [OW:0]    mem [FIFO_DEPTH];   // {last, sample}
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic           keep;
    logic           keep_last;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic [OW-1:0]  kept_data;

    // A frame_start with ce always keeps the current sample as frame sample 0,
    // whether starting from IDLE or restarting an active frame.
    assign keep       = ce && (frame_start || (state == ACTIVE && phase == '0));
    assign keep_last  = !frame_start && (sample_cnt == SAMPLE_MAX);
    assign kept_data  = data_i[IW-1 -: OW];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);
    assign pop        = !fifo_empty && ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push       = keep && (!fifo_full || pop);

    assign valid_o    = !fifo_empty;
    assign data_o     = fifo_empty ? '0 : mem[rd_ptr][OW-1:0];
    assign last_o     = fifo_empty ? 1'b0 : mem[rd_ptr][OW];
    assign busy_o     = (state == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            sample_cnt <= '0;
        end else if (frame_start) begin
            state <= ACTIVE;
            if (ce) begin
                phase      <= PHASE_NEXT;
                sample_cnt <= SW'(1);
            end else begin
                phase      <= '0;
                sample_cnt <= '0;
            end
        end else if (state == ACTIVE && ce) begin
            phase <= (phase == PHASE_MAX) ? '0 : phase + 1'b1;
            if (phase == '0) begin
                // Counters advance even when the FIFO drops the sample.
                if (keep_last) begin
                    sample_cnt <= '0;
                    state      <= IDLE;
                end else begin
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (keep && !push) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the read side is gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {keep_last, kept_data};
        end
    end

endmodule
